// File: rtl/vn_lut_pkg.sv
// Shared VN LUT definitions: table geometry, loader FSM encoding and checksum helper.
// Also used by sym_vn_rank / sym_vn_lut_out.
package vn_lut_pkg;

    localparam int VN_LUT_DATA_W   = 3;
    localparam int VN_LUT_ADDR_W   = 5;
    localparam int VN_LUT_PAGE_NUM = 32;
    localparam int VN_LUT_CSUM_W   = 8;

    typedef enum logic [1:0] {
        VN_IDLE = 2'd0,
        VN_LOAD = 2'd1,
        VN_DONE = 2'd2
    } vn_load_state_t;

    // Modulo-256 running sum of zero-extended LUT entries
    function automatic logic [VN_LUT_CSUM_W-1:0] vn_csum_add(
        input logic [VN_LUT_CSUM_W-1:0] sum,
        input logic [VN_LUT_DATA_W-1:0] entry
    );
        return sum + {{(VN_LUT_CSUM_W-VN_LUT_DATA_W){1'b0}}, entry};
    endfunction

endpackage

// File: rtl/vn_lut_loader_if.sv
// Valid/ready stream of LUT entries from the IB-LUT update controller into the loader.
interface vn_lut_loader_if;
    import vn_lut_pkg::*;

    logic [VN_LUT_DATA_W-1:0] lut_data_in;
    logic                     lut_valid;
    logic                     lut_ready;

    modport master (
        output lut_data_in,
        output lut_valid,
        input  lut_ready
    );

    modport slave (
        input  lut_data_in,
        input  lut_valid,
        output lut_ready
    );

endinterface

// File: rtl/vn_lut_csum.sv
// Load checksum: modulo-256 sum of accepted entries, compared against the expected value in DONE.
module vn_lut_csum
    import vn_lut_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     accept,
    input  logic [VN_LUT_DATA_W-1:0] entry,
    input  logic                     check,
    input  logic [VN_LUT_CSUM_W-1:0] csum_exp,
    output logic                     load_err
);

    logic [VN_LUT_CSUM_W-1:0] sum_r;

    // Running sum of the current load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 8'd0;
        end else if (clear) begin
            sum_r <= 8'd0;
        end else if (accept) begin
            sum_r <= vn_csum_add(sum_r, entry);
        end else begin
            sum_r <= sum_r;
        end
    end

    // Error flag sticks from the DONE cycle until the next load begins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err <= 1'b0;
        end else if (clear) begin
            load_err <= 1'b0;
        end else if (check) begin
            load_err <= (sum_r != csum_exp);
        end else begin
            load_err <= load_err;
        end
    end

endmodule

// File: rtl/vn_lut_loader.sv
// Write-side feeder of the symmetric VN LUT: page addressing, replicated write port, busy/done.
// Optional checksum build: define VN_LUT_LOAD_CHECKSUM_EN.
module vn_lut_loader
    import vn_lut_pkg::*;
#(
    parameter int DATA_W   = VN_LUT_DATA_W,
    parameter int ADDR_W   = VN_LUT_ADDR_W,
    parameter int PAGE_NUM = VN_LUT_PAGE_NUM
) (
    input  logic              write_clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    vn_lut_loader_if.slave    lut_in,
    (* keep = "true" *) output logic [DATA_W-1:0] lut_in_bank0_replicate_0,
    (* keep = "true" *) output logic [ADDR_W-1:0] page_write_addr_replicate_0,
    (* keep = "true" *) output logic [DATA_W-1:0] lut_in_bank0_replicate_1,
    (* keep = "true" *) output logic [ADDR_W-1:0] page_write_addr_replicate_1,
    output logic              we,
    output logic              load_busy,
    output logic              load_done
`ifdef VN_LUT_LOAD_CHECKSUM_EN
    ,
    input  logic [7:0]        lut_csum_exp,
    output logic              load_err
`endif
);

    localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(PAGE_NUM - 1);

    vn_load_state_t    state_r;
    vn_load_state_t    next_state_s;
    logic [ADDR_W-1:0] page_cnt_r;
    logic              ready_s;
    logic              accept_s;
    logic              start_s;

    // Handshake decode; ready ignores lut_valid so the upstream may wait on it
    always_comb begin
        ready_s  = (state_r == VN_LOAD) && !load_abort;
        accept_s = ready_s && lut_in.lut_valid;
        start_s  = (state_r == VN_IDLE) && load_start;
    end

    assign lut_in.lut_ready = ready_s;

    // Next-state logic; abort wins over a beat in the same cycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            VN_IDLE: begin
                if (load_start) begin
                    next_state_s = VN_LOAD;
                end else begin
                    next_state_s = VN_IDLE;
                end
            end
            VN_LOAD: begin
                if (load_abort) begin
                    next_state_s = VN_IDLE;
                end else if (accept_s && (page_cnt_r == LAST_PAGE)) begin
                    next_state_s = VN_DONE;
                end else begin
                    next_state_s = VN_LOAD;
                end
            end
            VN_DONE: begin
                next_state_s = VN_IDLE;
            end
            default: begin
                next_state_s = VN_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state_r <= VN_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Page counter; restarts at 0 on every load, wraps naturally at 2**ADDR_W
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            page_cnt_r <= '0;
        end else if (start_s) begin
            page_cnt_r <= '0;
        end else if (accept_s) begin
            page_cnt_r <= page_cnt_r + ADDR_W'(1);
        end else begin
            page_cnt_r <= page_cnt_r;
        end
    end

    // Replicated write port, one cycle behind the accepted beat
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            we                          <= 1'b0;
            lut_in_bank0_replicate_0    <= '0;
            page_write_addr_replicate_0 <= '0;
            lut_in_bank0_replicate_1    <= '0;
            page_write_addr_replicate_1 <= '0;
        end else if (accept_s) begin
            we                          <= 1'b1;
            lut_in_bank0_replicate_0    <= DATA_W'(lut_in.lut_data_in);
            page_write_addr_replicate_0 <= page_cnt_r;
            lut_in_bank0_replicate_1    <= DATA_W'(lut_in.lut_data_in);
            page_write_addr_replicate_1 <= page_cnt_r;
        end else begin
            we                          <= 1'b0;
            lut_in_bank0_replicate_0    <= lut_in_bank0_replicate_0;
            page_write_addr_replicate_0 <= page_write_addr_replicate_0;
            lut_in_bank0_replicate_1    <= lut_in_bank0_replicate_1;
            page_write_addr_replicate_1 <= page_write_addr_replicate_1;
        end
    end

    // Status flops track the state register exactly, from the same next-state value
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            load_busy <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_busy <= (next_state_s == VN_LOAD);
            load_done <= (next_state_s == VN_DONE);
        end
    end

`ifdef VN_LUT_LOAD_CHECKSUM_EN
    vn_lut_csum u_csum (
        .clk      (write_clk),
        .rst      (rst),
        .clear    (start_s),
        .accept   (accept_s),
        .entry    (VN_LUT_DATA_W'(lut_in.lut_data_in)),
        .check    (state_r == VN_DONE),
        .csum_exp (lut_csum_exp),
        .load_err (load_err)
    );
`endif

endmodule
